// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the mem_bus_arb memory bus arbiter: FSM state encoding,
// owner indices, one-hot grant masks and a grant-to-owner helper.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] CON = 2'd2;
    localparam logic [1:0] UBA = 2'd1;
    localparam logic [1:0] CPU = 2'd0;

    localparam logic [2:0] GNT_CON = 3'b100;
    localparam logic [2:0] GNT_UBA = 3'b010;
    localparam logic [2:0] GNT_CPU = 3'b001;

    function automatic logic [1:0] gnt_to_owner(input logic [2:0] gnt);
        if (gnt[CON])      return CON;
        else if (gnt[UBA]) return UBA;
        else               return CPU;
    endfunction

endpackage

// File: rtl/mem_bus_arb_rr3.sv
// arb_rr3: combinational 3-way round-robin picker. The search starts just after
// the last owner and walks con -> uba -> cpu -> con.
module arb_rr3
    import mem_bus_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        // NOTE: default first so every path assigns gnt_o and no latch is inferred.
        gnt_o = '0;
        case (last_i)
            CON: begin
                if      (req_i[UBA]) gnt_o = GNT_UBA;
                else if (req_i[CPU]) gnt_o = GNT_CPU;
                else if (req_i[CON]) gnt_o = GNT_CON;
            end
            UBA: begin
                if      (req_i[CPU]) gnt_o = GNT_CPU;
                else if (req_i[CON]) gnt_o = GNT_CON;
                else if (req_i[UBA]) gnt_o = GNT_UBA;
            end
            default: begin
                if      (req_i[CON]) gnt_o = GNT_CON;
                else if (req_i[UBA]) gnt_o = GNT_UBA;
                else if (req_i[CPU]) gnt_o = GNT_CPU;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: round-robin arbiter for the CPU, Unibus adapter and console memory bus.
// Define KS10_ARB_TIMEOUT_EN to build the non-existent-memory timeout abort.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDRW   = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic             cpuREQ,
    input  logic [ADDRW-1:0] cpuADDR,
    input  logic             ubaREQ,
    input  logic [ADDRW-1:0] ubaADDR,
    input  logic             conREQ,
    input  logic [ADDRW-1:0] conADDR,
    input  logic             memACK,
    output logic [ADDRW-1:0] busADDR,
    output logic             busVALID,
    output logic [2:0]       arbGNT,
    output logic [2:0]       arbACK,
    output logic             arbNXM,
    output logic             arbBUSY
);

    state_e           state_q;
    logic [2:0]       gnt_q;
    logic [2:0]       ack_q;
    logic             valid_q;
    logic             nxm_q;
    logic [ADDRW-1:0] addr_q;
    logic [1:0]       last_q;

    logic [2:0]       win;
    logic [ADDRW-1:0] win_addr;
    logic             timeout;

    arb_rr3 u_rr3 (
        .req_i  ({conREQ, ubaREQ, cpuREQ}),
        .last_i (last_q),
        .gnt_o  (win)
    );

    always_comb begin
        win_addr = cpuADDR;
        if (win[CON])      win_addr = conADDR;
        else if (win[UBA]) win_addr = ubaADDR;
    end

`ifdef KS10_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clken) begin
            if (state_q == ST_IDLE)      cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    // The abort fires on the TIMEOUT-th enabled WAIT cycle.
    assign timeout = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            nxm_q   <= 1'b0;
            addr_q  <= '0;
            last_q  <= CPU;
        end else if (clken) begin
            // NOTE: non-blocking assignments; every register updates from pre-edge values.
            valid_q <= 1'b0;
            ack_q   <= '0;
            nxm_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win != '0) begin
                        gnt_q   <= win;
                        addr_q  <= win_addr;
                        valid_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // memACK takes priority over a coincident timeout.
                    if (memACK) begin
                        ack_q   <= gnt_q;
                        state_q <= ST_DONE;
                    end else if (timeout) begin
                        ack_q   <= gnt_q;
                        nxm_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    last_q  <= gnt_to_owner(gnt_q);
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busADDR  = addr_q;
    assign busVALID = valid_q;
    assign arbGNT   = gnt_q;
    assign arbACK   = ack_q;
    assign arbNXM   = nxm_q;
    assign arbBUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed testbench for mem_bus_arb: a per-cycle vector table plus hand-written
// sequences for clock-enable throttling, reset during WAIT and the WAIT exit paths.
module tb_mem_bus_arb;

    localparam logic [35:0] CPU_A = 36'o000000001000;
    localparam logic [35:0] UBA_A = 36'o000000002000;
    localparam logic [35:0] CON_A = 36'o000000003000;

    logic        clk, rst_n, clken;
    logic        cpuREQ, ubaREQ, conREQ, memACK;
    logic [35:0] busADDR;
    logic        busVALID, arbNXM, arbBUSY;
    logic [2:0]  arbGNT, arbACK;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arb #(.TIMEOUT(8), .ADDRW(36)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clken    (clken),
        .cpuREQ   (cpuREQ),
        .cpuADDR  (CPU_A),
        .ubaREQ   (ubaREQ),
        .ubaADDR  (UBA_A),
        .conREQ   (conREQ),
        .conADDR  (CON_A),
        .memACK   (memACK),
        .busADDR  (busADDR),
        .busVALID (busVALID),
        .arbGNT   (arbGNT),
        .arbACK   (arbACK),
        .arbNXM   (arbNXM),
        .arbBUSY  (arbBUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       tag;
        logic        con, uba, cpu, mack;
        logic [2:0]  gnt, ack;
        logic        valid, busy;
        logic [35:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string tag, input logic con, input logic uba, input logic cpu,
                       input logic mack, input logic [2:0] gnt, input logic valid,
                       input logic [2:0] ack, input logic busy, input logic [35:0] addr);
        vec_t v;
        v.tag = tag; v.con = con; v.uba = uba; v.cpu = cpu; v.mack = mack;
        v.gnt = gnt; v.valid = valid; v.ack = ack; v.busy = busy; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".gnt"},   arbGNT,   3'b000);
        check({tag, ".ack"},   arbACK,   3'b000);
        check({tag, ".valid"}, busVALID, 1'b0);
        check({tag, ".nxm"},   arbNXM,   1'b0);
        check({tag, ".busy"},  arbBUSY,  1'b0);
        check({tag, ".addr"},  busADDR,  36'o0);
    endtask

    initial begin
        int en_edges, valid_en, ack_at, ack_cnt, idle_at, k_ack;
        logic [2:0] ack_val;
        logic nxm_val;

        rst_n = 1'b0; clken = 1'b1;
        cpuREQ = 1'b0; ubaREQ = 1'b0; conREQ = 1'b0; memACK = 1'b0;
        #1;
        check_idle_outputs("reset");
        #21 rst_n = 1'b1;

        // inputs: con uba cpu mack -> expected gnt valid ack busy addr (after the edge)
        add("cpu_start", 0,0,1,0, 3'b001,1,3'b000,1, CPU_A);
        add("cpu_wait1", 0,0,1,0, 3'b001,0,3'b000,1, CPU_A);
        add("cpu_wait2", 0,0,1,0, 3'b001,0,3'b000,1, CPU_A);
        add("cpu_wait3", 0,0,1,0, 3'b001,0,3'b000,1, CPU_A);
        add("cpu_done",  0,0,1,1, 3'b001,0,3'b001,1, CPU_A);
        add("cpu_idle",  0,0,0,0, 3'b000,0,3'b000,0, CPU_A);
        add("idle_mack", 0,0,0,1, 3'b000,0,3'b000,0, CPU_A);
        add("rr1_start", 1,1,1,0, 3'b100,1,3'b000,1, CON_A);
        add("rr1_wait",  1,1,1,0, 3'b100,0,3'b000,1, CON_A);
        add("rr1_done",  1,1,1,1, 3'b100,0,3'b100,1, CON_A);
        add("rr1_idle",  1,1,1,0, 3'b000,0,3'b000,0, CON_A);
        add("rr2_start", 1,1,1,0, 3'b010,1,3'b000,1, UBA_A);
        add("rr2_stmack",1,1,1,1, 3'b010,0,3'b000,1, UBA_A);
        add("rr2_done",  1,1,1,1, 3'b010,0,3'b010,1, UBA_A);
        add("rr2_idle",  1,1,1,0, 3'b000,0,3'b000,0, UBA_A);
        add("rr3_start", 1,1,1,0, 3'b001,1,3'b000,1, CPU_A);
        add("rr3_wait",  1,1,1,0, 3'b001,0,3'b000,1, CPU_A);
        add("rr3_drop",  1,1,0,1, 3'b001,0,3'b001,1, CPU_A);
        add("rr3_idle",  1,1,0,0, 3'b000,0,3'b000,0, CPU_A);
        add("rr4_start", 1,1,0,0, 3'b100,1,3'b000,1, CON_A);
        add("rr4_wait",  1,1,0,0, 3'b100,0,3'b000,1, CON_A);
        add("rr4_done",  1,1,0,1, 3'b100,0,3'b100,1, CON_A);
        add("rr4_idle",  0,0,0,0, 3'b000,0,3'b000,0, CON_A);

        foreach (vecs[i]) begin
            conREQ = vecs[i].con; ubaREQ = vecs[i].uba;
            cpuREQ = vecs[i].cpu; memACK = vecs[i].mack;
            tick();
            check({vecs[i].tag, ".gnt"},   arbGNT,   vecs[i].gnt);
            check({vecs[i].tag, ".valid"}, busVALID, vecs[i].valid);
            check({vecs[i].tag, ".ack"},   arbACK,   vecs[i].ack);
            check({vecs[i].tag, ".busy"},  arbBUSY,  vecs[i].busy);
            check({vecs[i].tag, ".nxm"},   arbNXM,   1'b0);
            check({vecs[i].tag, ".addr"},  busADDR,  vecs[i].addr);
        end
        conREQ = 0; ubaREQ = 0; cpuREQ = 0; memACK = 0;

        // clken 1-of-3 with a single console request
        en_edges = 0; valid_en = 0; ack_at = 0; ack_cnt = 0; idle_at = 0; ack_val = '0;
        conREQ = 1'b1;
        for (int i = 0; i < 60 && idle_at == 0; i++) begin
            clken  = (i % 3 == 0);
            memACK = clken && arbBUSY && !busVALID && (arbACK == 3'b000);
            tick();
            if (arbACK != 3'b000) conREQ = 1'b0;
            if (clken) begin
                en_edges++;
                if (busVALID) valid_en++;
                if (arbACK != 3'b000) begin
                    ack_cnt++;
                    if (ack_at == 0) begin ack_at = en_edges; ack_val = arbACK; end
                end
                if (!arbBUSY && idle_at == 0) idle_at = en_edges;
            end
        end
        clken = 1'b1; memACK = 1'b0; conREQ = 1'b0;
        check("clken.valid_cycles", valid_en, 1);
        check("clken.ack_edge",     ack_at,   3);
        check("clken.ack_pulses",   ack_cnt,  1);
        check("clken.ack_owner",    ack_val,  3'b100);
        check("clken.idle_edge",    idle_at,  4);

        // reset asserted while uba waits for memory
        ubaREQ = 1'b1;
        tick();
        check("rst.pre_gnt", arbGNT, 3'b010);
        tick();
        check("rst.pre_wait", {busVALID, arbBUSY}, 2'b01);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst.async");
        tick();
        tick();
        check("rst.held_ack", arbACK, 3'b000);
        #3 rst_n = 1'b1;
        tick();
        check("rst.regrant_gnt",   arbGNT,   3'b010);
        check("rst.regrant_valid", busVALID, 1'b1);
        check("rst.regrant_addr",  busADDR,  UBA_A);
        tick();
        check("wait.entry", {busVALID, arbBUSY}, 2'b01);

`ifdef KS10_ARB_TIMEOUT_EN
        k_ack = 0; nxm_val = 1'b0; ack_val = '0;
        for (int k = 1; k <= 20 && k_ack == 0; k++) begin
            tick();
            if (arbACK != 3'b000) begin k_ack = k; nxm_val = arbNXM; ack_val = arbACK; end
        end
        ubaREQ = 1'b0;
        check("tmo.ack_edge", k_ack,   8);
        check("tmo.nxm",      nxm_val, 1'b1);
        check("tmo.ack",      ack_val, 3'b010);
        tick();
        check("tmo.idle", {arbBUSY, arbNXM, arbGNT}, 5'b0);

        ubaREQ = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 7; k++) tick();
        check("tmo_tie.pre_ack", arbACK, 3'b000);
        memACK = 1'b1;
        tick();
        memACK = 1'b0; ubaREQ = 1'b0;
        check("tmo_tie.ack", arbACK, 3'b010);
        check("tmo_tie.nxm", arbNXM, 1'b0);
        tick();
        check("tmo_tie.idle", arbBUSY, 1'b0);
`else
        k_ack = 0; nxm_val = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (arbACK != 3'b000) k_ack++;
            if (arbNXM) nxm_val = 1'b1;
        end
        check("nowait.acks", k_ack,   0);
        check("nowait.nxm",  nxm_val, 1'b0);
        check("nowait.busy", arbBUSY, 1'b1);
        memACK = 1'b1;
        tick();
        memACK = 1'b0; ubaREQ = 1'b0;
        check("nowait.ack", arbACK, 3'b010);
        check("nowait.nxm_ack", arbNXM, 1'b0);
        tick();
        check("nowait.idle", arbBUSY, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
